divider_unsigned: RTL and testbench



---
 rtl/divider_unsigned.sv | 90 +++++++++
 tb/tb_divider_unsigned.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/divider_unsigned.sv
// divider_unsigned: multi-cycle restoring unsigned divider, one quotient bit per clock.
// Optional macro DIV_BY_ZERO_FLAG_EN adds a div_zero output flagged with vldout.
module divider_unsigned #(
    parameter int WID0 = 32,
    parameter int WID1 = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            vldin,
    input  logic [WID0-1:0] arg0,
    input  logic [WID1-1:0] arg1,
    output logic            vldout,
    output logic            busy,
    output logic [WID1-1:0] remainder,
    output logic [WID0-1:0] result
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    output logic            div_zero
`endif
);
    localparam int CW = $clog2(WID0);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [WID0-1:0] quo;
    logic [WID1-1:0] dvs, rem, rem_nxt;
    logic [WID1:0]   trial;
    logic            fit;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic            dz;
`endif
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state and one restoring step; the dividend register doubles as the quotient shifter
    always_comb begin
        trial     = {rem, quo[WID0-1]};
        fit       = trial >= {1'b0, dvs};
        rem_nxt   = WID1'(fit ? trial - {1'b0, dvs} : trial);
        busy      = state != IDLE;
        state_nxt = (state == IDLE && vldin)                 ? RUN  :
                    (state == RUN && cnt == CW'(WID0 - 1))   ? DONE :
                    (state == DONE)                          ? IDLE : state;
    end
    // datapath: latch on accept, iterate in RUN, publish in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            quo       <= '0;
            dvs       <= '0;
            rem       <= '0;
            result    <= '0;
            remainder <= '0;
            vldout    <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
            dz        <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            vldout <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
            div_zero <= 1'b0;
`endif
            if (state == IDLE && vldin) begin
                quo <= arg0;
                dvs <= arg1;
                rem <= '0;
                cnt <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
                dz  <= arg1 == '0;
`endif
            end
            if (state == RUN) begin
                quo <= {quo[WID0-2:0], fit};
                rem <= rem_nxt;
                cnt <= cnt + 1'b1;
            end
            if (state == DONE) begin
                result    <= quo;
                remainder <= rem;
                vldout    <= 1'b1;
`ifdef DIV_BY_ZERO_FLAG_EN
                div_zero  <= dz;
`endif
            end
        end
    end
endmodule

// File: tb/tb_divider_unsigned.sv
// tb_divider_unsigned: directed vector table plus handshake corner sequences for divider_unsigned.
module tb_divider_unsigned;
    localparam int W0 = 32;
    localparam int W1 = 16;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vldin = 1'b0;
    logic [W0-1:0] arg0 = '0;
    logic [W1-1:0] arg1 = '0;
    logic          vldout, busy;
    logic [W1-1:0] remainder;
    logic [W0-1:0] result;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic          div_zero;
`endif
    int            nvec = 0;
    int            nerr = 0;
    logic [W0-1:0] prev_q = '0;

    typedef struct {
        logic [W0-1:0] a;
        logic [W1-1:0] b;
        logic [W0-1:0] q;
        logic [W1-1:0] r;
    } vec_t;
    vec_t vt[12];

    divider_unsigned #(.WID0(W0), .WID1(W1)) dut (
        .clk(clk), .rst_n(rst_n), .vldin(vldin), .arg0(arg0), .arg1(arg1),
        .vldout(vldout), .busy(busy), .remainder(remainder), .result(result)
`ifdef DIV_BY_ZERO_FLAG_EN
        , .div_zero(div_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // called at a negedge; accepting edge is the next posedge
    task automatic start(input logic [W0-1:0] a, input logic [W1-1:0] b);
        vldin = 1'b1;
        arg0  = a;
        arg1  = b;
        @(negedge clk);
        vldin = 1'b0;
        chk("accept_busy", busy, 1);
        chk("no_early_vldout", vldout, 0);
    endtask

    // returns at the negedge where vldout is high
    task automatic wait_done(input logic [W0-1:0] q, input logic [W1-1:0] r, input logic dz, input bit inject);
        int n = 0;
        bit bad = 1'b0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (inject && i == 5) begin
                vldin = 1'b1;
                arg0  = 999;
                arg1  = 3;
            end
            if (inject && i == 6) vldin = 1'b0;
            if (i == 10) chk("result_hold", result, prev_q);
            if (vldout) n = i;
            else if (!busy) bad = 1'b1;
        end
        chk("latency", n, 33);
        chk("busy_during_job", bad, 0);
        chk("busy_drop", busy, 0);
        chk("result", result, q);
        chk("remainder", remainder, r);
`ifdef DIV_BY_ZERO_FLAG_EN
        chk("div_zero", div_zero, dz);
`else
        if (dz && !vldout) $display("note: zero divisor job without vldout");
`endif
        prev_q = q;
    endtask

    initial begin
        bit seen;
        vt[0]  = '{32'd100, 16'd7, 32'd14, 16'd2};
        vt[1]  = '{32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0};
        vt[2]  = '{32'd5, 16'hFFFF, 32'd0, 16'd5};
        vt[3]  = '{32'd1234, 16'd0, 32'hFFFF_FFFF, 16'd1234};
        vt[4]  = '{32'd0, 16'd5, 32'd0, 16'd0};
        vt[5]  = '{32'hFFFE_0001, 16'hFFFF, 32'h0000_FFFF, 16'd0};
        vt[6]  = '{32'd1000000, 16'd1000, 32'd1000, 16'd0};
        vt[7]  = '{32'd123456789, 16'd12345, 32'd10000, 16'd6789};
        vt[8]  = '{32'h8000_0000, 16'd2, 32'h4000_0000, 16'd0};
        vt[9]  = '{32'hDEAD_BEEF, 16'h10, 32'h0DEA_DBEE, 16'hF};
        vt[10] = '{32'd7, 16'd9, 32'd0, 16'd7};
        vt[11] = '{32'd70000, 16'd0, 32'hFFFF_FFFF, 16'd4464};

        // reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (vldout || busy) seen = 1'b1;
        end
        chk("idle_activity", seen, 0);
        chk("reset_result", result, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_busy", busy, 0);

        // 100/7 with an ignored vldin mid-job, then a job accepted in the vldout cycle
        start(100, 7);
        wait_done(14, 2, 1'b0, 1'b1);
        start(50, 6);
        wait_done(8, 2, 1'b0, 1'b0);
        @(negedge clk);
        chk("vldout_one_cycle", vldout, 0);

        // reset at step 10 aborts the job
        start(500, 7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vldout || busy) seen = 1'b1;
        end
        chk("abort_no_vldout", seen, 0);
        prev_q = '0;

        // directed table
        for (int i = 0; i < 12; i++) begin
            start(vt[i].a, vt[i].b);
            wait_done(vt[i].q, vt[i].r, vt[i].b == '0, 1'b0);
        end

        // short random run against the language operators
        for (int i = 0; i < 20; i++) begin
            logic [W0-1:0] a;
            logic [W1-1:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W1'($urandom_range(0, 3)) : W1'($urandom);
            start(a, b);
            if (b == '0) wait_done('1, a[W1-1:0], 1'b1, 1'b0);
            else         wait_done(a / W0'(b), W1'(a % W0'(b)), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
